// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
// The stage is the master; the memory (or a model of it) is the slave.
interface mem_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, data-memory req/ack FSM and MEM/WB register.
// Upstream stages are frozen while a load or store is outstanding in M.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        pcsrc_e,
    input  logic        regwrite_e,
    input  logic        memtoreg_e,
    input  logic        memwrite_e,
    input  logic [31:0] aluresult_e,
    input  logic [31:0] writedata_e,
    input  logic [3:0]  writeaddr_e,
    mem_stage_if.master dmem,
    output logic        dmem_err,
    output logic        stall_mem,
    output logic [31:0] aluresult_m,
    output logic        regwrite_m,
    output logic [3:0]  writeaddr_m,
    output logic        pcsrc_w,
    output logic        regwrite_w,
    output logic        memtoreg_w,
    output logic [31:0] aluout_w,
    output logic [31:0] readdata_w,
    output logic [3:0]  writeaddr_w
);

    typedef struct packed {
        logic        pcsrc;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic [31:0] aluresult;
        logic [31:0] writedata;
        logic [3:0]  writeaddr;
    } exmem_t;

    typedef struct packed {
        logic        pcsrc;
        logic        regwrite;
        logic        memtoreg;
        logic [31:0] aluout;
        logic [31:0] readdata;
        logic [3:0]  writeaddr;
    } memwb_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    exmem_t           w_ex;
    exmem_t           r_m;
    memwb_t           r_w;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hold;
    logic             r_err;
    logic             w_memop;
    logic             w_stall;
    logic             w_req;
    logic             w_in_wait;
    logic             w_ack;
    logic             w_timeout;

    // A flushed slot keeps its data but can never write or branch.
    always_comb begin
        w_ex           = '0;
        w_ex.pcsrc     = pcsrc_e    & ~flush;
        w_ex.regwrite  = regwrite_e & ~flush;
        w_ex.memtoreg  = memtoreg_e & ~flush;
        w_ex.memwrite  = memwrite_e & ~flush;
        w_ex.aluresult = aluresult_e;
        w_ex.writedata = writedata_e;
        w_ex.writeaddr = writeaddr_e;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m <= '0;
        end else if (!w_stall) begin
            r_m <= w_ex;
        end
    end

    assign w_memop   = r_m.memtoreg | r_m.memwrite;
    assign w_in_wait = (r_state == S_WAIT);
    assign w_ack     = w_in_wait & dmem.dmem_ack;
    assign w_timeout = w_in_wait & ~dmem.dmem_ack
                     & (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_memop) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // DONE is the one cycle in which a memory op may leave M.
    always_comb begin
        w_req   = 1'b0;
        w_stall = w_memop;
        unique case (r_state)
            S_IDLE: w_req = w_memop;
            S_WAIT: w_req = 1'b1;
            S_DONE: w_stall = 1'b0;
            default: begin
                w_req   = 1'b0;
                w_stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_in_wait) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
        end else if (w_ack) begin
            r_hold <= dmem.dmem_rdata;
        end else if (w_timeout) begin
            r_hold <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    // While stalled, writeback sees a bubble so the op retires only once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w <= '0;
        end else begin
            r_w.pcsrc     <= r_m.pcsrc    & ~w_stall;
            r_w.regwrite  <= r_m.regwrite & ~w_stall;
            r_w.memtoreg  <= r_m.memtoreg & ~w_stall;
            r_w.aluout    <= r_m.aluresult;
            r_w.readdata  <= r_hold;
            r_w.writeaddr <= r_m.writeaddr;
        end
    end

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = r_m.memwrite;
    assign dmem.dmem_addr  = r_m.aluresult;
    assign dmem.dmem_wdata = r_m.writedata;

    assign dmem_err    = r_err;
    assign stall_mem   = w_stall;
    assign aluresult_m = r_m.aluresult;
    assign regwrite_m  = r_m.regwrite;
    assign writeaddr_m = r_m.writeaddr;
    assign pcsrc_w     = r_w.pcsrc;
    assign regwrite_w  = r_w.regwrite;
    assign memtoreg_w  = r_w.memtoreg;
    assign aluout_w    = r_w.aluout;
    assign readdata_w  = r_w.readdata;
    assign writeaddr_w = r_w.writeaddr;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: vector table, directed memory sequences and a
// randomized run against a transaction-level pipeline and memory model.
module tb_mem_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        pcsrc_e, regwrite_e, memtoreg_e, memwrite_e;
    logic [31:0] aluresult_e, writedata_e;
    logic [3:0]  writeaddr_e;
    logic        dmem_err, stall_mem;
    logic [31:0] aluresult_m;
    logic        regwrite_m;
    logic [3:0]  writeaddr_m;
    logic        pcsrc_w, regwrite_w, memtoreg_w;
    logic [31:0] aluout_w, readdata_w;
    logic [3:0]  writeaddr_w;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .pcsrc_e     (pcsrc_e),
        .regwrite_e  (regwrite_e),
        .memtoreg_e  (memtoreg_e),
        .memwrite_e  (memwrite_e),
        .aluresult_e (aluresult_e),
        .writedata_e (writedata_e),
        .writeaddr_e (writeaddr_e),
        .dmem        (bus),
        .dmem_err    (dmem_err),
        .stall_mem   (stall_mem),
        .aluresult_m (aluresult_m),
        .regwrite_m  (regwrite_m),
        .writeaddr_m (writeaddr_m),
        .pcsrc_w     (pcsrc_w),
        .regwrite_w  (regwrite_w),
        .memtoreg_w  (memtoreg_w),
        .aluout_w    (aluout_w),
        .readdata_w  (readdata_w),
        .writeaddr_w (writeaddr_w)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, pc, rw, mr, mw,
                         input logic [31:0] a, d, input logic [3:0] wa);
        flush       = f;
        pcsrc_e     = pc;
        regwrite_e  = rw;
        memtoreg_e  = mr;
        memwrite_e  = mw;
        aluresult_e = a;
        writedata_e = d;
        writeaddr_e = wa;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    endtask

    // Acts as the memory for one op already in M; ack on request cycle ack_at
    // (0 = never). Returns at the first cycle with neither req nor stall.
    task automatic serve(input int ack_at, input logic [31:0] rd,
                         output int nreq, output int nst,
                         output logic we, output logic [31:0] wd);
        nreq = 0;
        nst  = 0;
        we   = 1'b0;
        wd   = 32'h0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.dmem_req && !stall_mem) begin
                bus.dmem_ack = 1'b0;
                return;
            end
            if (bus.dmem_req) begin
                nreq++;
                we = bus.dmem_we;
                wd = bus.dmem_wdata;
            end
            if (stall_mem) nst++;
            bus.dmem_ack   = (nreq == ack_at);
            bus.dmem_rdata = rd;
            step();
        end
        bus.dmem_ack = 1'b0;
        nreq = -1;
    endtask

    typedef struct {
        logic        f, pc, rw;
        logic [31:0] a;
        logic [3:0]  wa;
        logic        x_rwm, x_pcw;
    } vec_t;

    typedef struct packed {
        logic        pc, rw, mr, mw;
        logic [31:0] a, d, rd;
        logic [3:0]  wa;
    } op_t;

    function automatic op_t rand_op();
        op_t o;
        int  k;
        o    = '0;
        k    = $urandom_range(0, 4);
        o.a  = $urandom;
        o.d  = $urandom;
        o.wa = 4'($urandom);
        if (k == 0) begin
            o.rw = 1'b1;
        end else if (k == 1) begin
            o.mr = 1'b1;
            o.rw = 1'b1;
            o.a  = {26'h0, 4'($urandom), 2'b00};
        end else if (k == 2) begin
            o.mw = 1'b1;
            o.rw = 1'($urandom);
            o.a  = {26'h0, 4'($urandom), 2'b00};
        end else if (k == 3) begin
            o.pc = 1'b1;
        end
        return o;
    endfunction

    vec_t        vecs [6];
    int          nreq, nst;
    logic        we;
    logic [31:0] wd;
    logic [31:0] mem [16];
    op_t         e_op, m_op, w_exp;
    logic        e_flush, prev_st, st, memop, err_m, err_pend, w_valid;
    int          occ, lat;
    logic [3:0]  idx;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        nop();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
        step();
        step();
        chk("rst_ctl", {bus.dmem_req, stall_mem, dmem_err, pcsrc_w,
                        regwrite_w, memtoreg_w, regwrite_m}, 7'b0);
        chk("rst_data", {aluout_w, readdata_w}, 64'h0);
        chk("rst_m", {aluresult_m, writeaddr_m}, 36'h0);
        reset = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h10,       4'd3,  1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h22,       4'd4,  1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h100,      4'd15, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h5,        4'd1,  1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 4'd0,  1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h80000000, 4'd9,  1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].f, vecs[i].pc, vecs[i].rw, 0, 0,
                  vecs[i].a, 32'h0, vecs[i].wa);
            step();
            chk("vec_rw_m", regwrite_m, vecs[i].x_rwm);
            chk("vec_stall", stall_mem, 0);
            if (!vecs[i].f) chk("vec_tap", {aluresult_m, writeaddr_m},
                                {vecs[i].a, vecs[i].wa});
            nop();
            step();
            chk("vec_ctl_w", {pcsrc_w, regwrite_w, memtoreg_w},
                {vecs[i].x_pcw, vecs[i].x_rwm, 1'b0});
            if (!vecs[i].f) chk("vec_data_w", {aluout_w, writeaddr_w},
                                {vecs[i].a, vecs[i].wa});
        end

        drive(0, 0, 1, 1, 0, 32'h40, 32'h0, 4'd5);
        step();
        chk("ld_addr", {bus.dmem_we, bus.dmem_addr}, {1'b0, 32'h40});
        nop();
        serve(3, 32'hDEADBEEF, nreq, nst, we, wd);
        chk("ld_nreq", nreq, 3);
        chk("ld_nstall", nst, 3);
        chk("ld_we", we, 0);
        chk("ld_no_early_wb", {regwrite_w, memtoreg_w}, 2'b00);
        step();
        chk("ld_rdata", readdata_w, 32'hDEADBEEF);
        chk("ld_wb", {regwrite_w, memtoreg_w, writeaddr_w}, {2'b11, 4'd5});
        step();
        chk("ld_single_wb", {regwrite_w, memtoreg_w}, 2'b00);

        drive(0, 0, 0, 0, 1, 32'h80, 32'h1234, 4'd0);
        step();
        drive(0, 0, 1, 1, 0, 32'h80, 32'h0, 4'd6);
        serve(2, 32'h0, nreq, nst, we, wd);
        chk("st_nreq", nreq, 2);
        chk("st_win", {we, wd}, {1'b1, 32'h1234});
        chk("st_gap_done", bus.dmem_req, 0);
        step();
        chk("ld2_req_next", bus.dmem_req, 1);
        nop();
        serve(2, 32'h1234, nreq, nst, we, wd);
        chk("ld2_nreq", nreq, 2);
        chk("ld2_we", we, 0);
        step();
        chk("ld2_wb", {readdata_w, memtoreg_w, writeaddr_w},
            {32'h1234, 1'b1, 4'd6});

        drive(1, 0, 1, 0, 0, 32'h55, 32'h0, 4'd2);
        step();
        chk("fl_rw_m", regwrite_m, 0);
        drive(0, 0, 1, 1, 0, 32'h44, 32'h0, 4'd7);
        step();
        drive(1, 0, 1, 0, 0, 32'h66, 32'h0, 4'd8);
        serve(2, 32'hCAFEF00D, nreq, nst, we, wd);
        chk("fl_ld_nreq", nreq, 2);
        chk("fl_hold_addr", aluresult_m, 32'h44);
        step();
        chk("fl_ld_wb", {readdata_w, regwrite_w, memtoreg_w, writeaddr_w},
            {32'hCAFEF00D, 2'b11, 4'd7});
        chk("fl_after", regwrite_m, 0);
        nop();

        drive(0, 0, 1, 1, 0, 32'h48, 32'h0, 4'd9);
        step();
        nop();
        chk("to_err_pre", dmem_err, 0);
        serve(0, 32'hFFFFFFFF, nreq, nst, we, wd);
        chk("to_nreq", nreq, TO + 1);
        chk("to_nstall", nst, TO + 1);
        chk("to_err", dmem_err, 1);
        step();
        chk("to_rdata", {readdata_w, memtoreg_w}, {32'h0, 1'b1});
        drive(0, 0, 1, 0, 0, 32'h77, 32'h0, 4'd1);
        step();
        chk("to_resume", {stall_mem, regwrite_m, aluresult_m},
            {2'b01, 32'h77});
        nop();
        step();
        chk("to_sticky", dmem_err, 1);

        drive(0, 0, 1, 1, 0, 32'h4C, 32'h0, 4'd3);
        step();
        nop();
        step();
        chk("rst_pre_req", bus.dmem_req, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid", {bus.dmem_req, stall_mem, dmem_err, pcsrc_w,
                        regwrite_w, memtoreg_w}, 6'b0);
        chk("rst_mid_w", {aluout_w, readdata_w, writeaddr_w}, 68'h0);
        step();
        reset = 1'b0;
        drive(0, 0, 1, 1, 0, 32'h50, 32'h0, 4'd4);
        step();
        nop();
        serve(2, 32'h600D, nreq, nst, we, wd);
        chk("rst_idle_nreq", nreq, 2);
        step();
        chk("rst_ld_wb", readdata_w, 32'h600D);

        reset = 1'b1;
        step();
        reset    = 1'b0;
        m_op     = '0;
        prev_st  = 1'b0;
        err_m    = 1'b0;
        err_pend = 1'b0;
        occ      = 0;
        lat      = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        e_op    = rand_op();
        e_flush = 1'b0;
        drive(0, e_op.pc, e_op.rw, e_op.mr, e_op.mw, e_op.a, e_op.d, e_op.wa);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            step();
            if (err_pend) begin
                err_m    = 1'b1;
                err_pend = 1'b0;
            end
            if (!prev_st) begin
                w_exp   = m_op;
                w_valid = 1'b1;
                m_op    = e_op;
                if (e_flush) begin
                    m_op.pc = 0;
                    m_op.rw = 0;
                    m_op.mr = 0;
                    m_op.mw = 0;
                end
                occ = 0;
                lat = ($urandom_range(0, 19) == 0) ? TO
                                                   : $urandom_range(1, 4);
            end else begin
                w_valid = 1'b0;
                occ++;
            end
            if (w_valid) begin
                chk("r_ctl_w", {pcsrc_w, regwrite_w, memtoreg_w},
                    {w_exp.pc, w_exp.rw, w_exp.mr});
                chk("r_data_w", {aluout_w, writeaddr_w}, {w_exp.a, w_exp.wa});
                if (w_exp.mr) chk("r_rdata_w", readdata_w, w_exp.rd);
            end else begin
                chk("r_bubble_w", {pcsrc_w, regwrite_w, memtoreg_w}, 3'b000);
            end
            memop = m_op.mr | m_op.mw;
            st    = memop && (occ <= lat);
            chk("r_stall", stall_mem, st);
            chk("r_req", bus.dmem_req, st);
            chk("r_tap", {regwrite_m, writeaddr_m, aluresult_m},
                {m_op.rw, m_op.wa, m_op.a});
            chk("r_we", bus.dmem_we, m_op.mw);
            chk("r_err", dmem_err, err_m);
            if (memop) chk("r_bus", {bus.dmem_addr, bus.dmem_wdata},
                           {m_op.a, m_op.d});
            idx            = m_op.a[5:2];
            bus.dmem_ack   = 1'b0;
            bus.dmem_rdata = $urandom;
            if (memop && occ == lat && lat != TO) begin
                bus.dmem_ack = 1'b1;
                if (m_op.mw) begin
                    mem[idx] = m_op.d;
                end else begin
                    bus.dmem_rdata = mem[idx];
                    m_op.rd        = mem[idx];
                end
            end else if (memop && occ == lat) begin
                m_op.rd  = 32'h0;
                err_pend = 1'b1;
            end else if (!(memop && occ >= 1 && occ <= lat)) begin
                bus.dmem_ack = ($urandom_range(0, 3) == 0);
            end
            if (!st) e_op = rand_op();
            e_flush = ($urandom_range(0, 5) == 0);
            drive(e_flush, e_op.pc, e_op.rw, e_op.mr, e_op.mw,
                  e_op.a, e_op.d, e_op.wa);
            prev_st = st;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the pipelined ARM core. It sits directly downstream of the execute stage and holds the EX/MEM pipeline register. It runs a req/ack handshake with the data memory and stalls the upstream pipeline while an access is outstanding. It produces the MEM/WB register values consumed by writeback, plus the forwarding taps used by the execute-stage operand muxes.

Parameters:
TIMEOUT, 16, maximum number of cycles spent in WAIT before the access is abandoned
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high
flush  in  1  load a bubble into EX/MEM in place of execute results
pcsrc_e  in  1  execute-stage PC-write flag, already condition-gated
regwrite_e  in  1  execute-stage register write, already condition-gated
memtoreg_e  in  1  execute-stage load
memwrite_e  in  1  execute-stage store, already condition-gated
aluresult_e  in  32  ALU result / memory address
writedata_e  in  32  store data
writeaddr_e  in  4  destination register
dmem_ack  in  1  memory completes the access this cycle
dmem_rdata  in  32  load data, valid when dmem_ack=1
dmem_req  out  1  access request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  32  byte address
dmem_wdata  out  32  store data
dmem_err  out  1  sticky timeout error
stall_mem  out  1  freeze the fetch, decode and execute registers
aluresult_m  out  32  forwarding tap
regwrite_m  out  1  forwarding tap
writeaddr_m  out  4  forwarding tap
pcsrc_w, regwrite_w, memtoreg_w  out  1 each  MEM/WB control bits
aluout_w  out  32  MEM/WB ALU result
readdata_w  out  32  MEM/WB load data
writeaddr_w  out  4  MEM/WB destination register

Behaviour:
- Reset: all registers, outputs and counters go to 0; FSM goes to IDLE. Reset in the middle of an access drops dmem_req at once; the access is not replayed.
- memop_m is defined as memtoreg_m | memwrite_m. The EX/MEM register holds memtoreg_m and memwrite_m internally.
- EX/MEM register loads at each rising edge when stall_mem=0.
  - If flush=1 on that edge, all control bits load as 0; data fields are don't-care.
  - When stall_mem=1 the register holds its value and flush is ignored, because the older memory op must complete.
- dmem_addr, dmem_wdata and dmem_we are driven directly from the EX/MEM fields. dmem_we = memwrite_m.
- FSM states:
  - IDLE: if memop_m=1, drive dmem_req=1 and go to WAIT; otherwise stay in IDLE.
  - WAIT: hold dmem_req=1 and increment the counter.
    - On dmem_ack=1: capture dmem_rdata into the hold register, drop the request, go to DONE.
    - Else, if the counter equals TIMEOUT-1: set dmem_err, load the hold register with 0, go to DONE.
  - DONE: dmem_req=0 and the counter clears. The register advances at the end of this cycle; go to IDLE.
- Memory ack is sampled only in WAIT. An ack while in IDLE or DONE is ignored.
- stall_mem = memop_m & (state != DONE), which is combinational.
  - Minimum occupancy of a memory op in M is 3 cycles: IDLE, WAIT with ack, DONE.
  - Non-memory ops pass through in 1 cycle with no stall.
- Back-to-back memory ops: DONE → IDLE → the new op issues its request in that IDLE cycle. There are no dead cycles beyond the FSM sequence.
- MEM/WB register loads every cycle when stall_mem=0, with readdata_w = hold register. When stall_mem=1 it loads a bubble: all control bits 0. This avoids a duplicated writeback.
- dmem_err stays high until reset.
- A store writes nothing to the register file unless regwrite_m=1; regwrite is passed through unchanged.

Test Plan:
- Reset asserted mid-WAIT with dmem_ack=0 → dmem_req, stall_mem, all *_w outputs and dmem_err read 0 in the same cycle; FSM is in IDLE after release.
- ADD writing R3 with aluresult_e=0x10 → next cycle aluresult_m=0x10, writeaddr_m=3, regwrite_m=1, stall_mem=0; one cycle later aluout_w=0x10, regwrite_w=1.
- Load from addr 0x40, ack after 2 WAIT cycles with rdata 0xDEADBEEF → dmem_req high for 3 cycles, dmem_we=0, stall_mem high 3 cycles; then readdata_w=0xDEADBEEF, memtoreg_w=1, exactly one writeback.
- Store 0x1234 to 0x80 followed immediately by a load from 0x80 → two distinct request windows separated by one DONE cycle; the first window has dmem_we=1 and dmem_wdata=0x1234, the second has dmem_we=0.
- flush=1 with regwrite_e=1 while stall_mem=0 → regwrite_m=0 next cycle. flush=1 during a stalled load → ignored and the load completes normally.
- Load with dmem_ack never asserted, TIMEOUT=16 → dmem_err rises after 16 WAIT cycles, readdata_w=0, the pipeline resumes, and dmem_err stays 1 until reset.
